instr_fetch_unit: RTL

//   Producer side of the opcode interface into the control decoder. Holds the PC and

---
 rtl/instr_fetch_unit_pkg.sv | 25 ++
 rtl/instr_fetch_unit_pc_next_calc.sv | 45 ++++
 rtl/instr_fetch_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch unit: MIPS opcode constants, fetch FSM
// state encoding and next-PC source selection.
package instr_fetch_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    IF_FETCH   = 2'b00,
    IF_ISSUE   = 2'b01,
    IF_RESOLVE = 2'b10
  } if_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_JUMP   = 2'b01,
    SEL_BRANCH = 2'b10
  } pc_sel_e;

endpackage

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Combinational next-PC: sequential (pc_out+4), j target or beq/bne target,
// all modulo 2^AW.
module pc_next_calc
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic [AW-1:0] pc_out,
  input  logic [31:0]   instr,
  input  pc_sel_e       sel,
  output logic [AW-1:0] pc_next
);

  localparam int unsigned MW = (AW < 28) ? AW : 28;

  logic [AW-1:0] pc_plus4;
  logic [AW-1:0] jump_target;
  logic [AW-1:0] branch_target;
  logic [AW-1:0] offset_sext;
  logic [27:0]   jump_field;
  logic          unused_opcode;

  assign unused_opcode = ^instr[31:26];
  assign pc_plus4      = pc_out + AW'(4);
  assign jump_field    = {instr[25:0], 2'b00};
  assign offset_sext   = AW'({{AW{instr[15]}}, instr[15:0]});
  assign branch_target = pc_plus4 + (offset_sext << 2);

  // Low MW bits come from the jump field; anything above keeps pc_out+4.
  always_comb begin
    jump_target = pc_plus4;
    for (int unsigned i = 0; i < MW; i++) begin
      jump_target[i] = jump_field[i];
    end
  end

  always_comb begin
    case (sel)
      SEL_JUMP:   pc_next = jump_target;
      SEL_BRANCH: pc_next = branch_target;
      default:    pc_next = pc_plus4;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches over a req/ready handshake and
// presents each instruction to decode until accepted; redirects on j/beq/bne.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned   AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic [31:0]   imem_rdata,
  output logic          instr_valid,
  output logic [31:0]   instr,
  output logic [5:0]    opcode,
  output logic [5:0]    funct,
  output logic [AW-1:0] pc_out,
  input  logic          instr_accept,
  input  logic          br_resolved,
  input  logic          br_taken
);

  if_state_e     state, state_next;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_target;
  pc_sel_e       sel;
  logic          capture;
  logic          consume;
  logic          load_pc;

  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];

  pc_next_calc #(.AW(AW)) u_pc_next_calc (
    .pc_out  (pc_out),
    .instr   (instr),
    .sel     (sel),
    .pc_next (pc_target)
  );

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    consume    = 1'b0;
    load_pc    = 1'b0;
    sel        = SEL_SEQ;
    case (state)
      IF_FETCH: begin
        if (imem_req && imem_ready) begin
          capture    = 1'b1;
          state_next = IF_ISSUE;
        end
      end
      IF_ISSUE: begin
        // br_resolved is deliberately ignored here, even alongside accept.
        if (instr_valid && instr_accept) begin
          consume = 1'b1;
          case (opcode)
            OP_J: begin
              sel        = SEL_JUMP;
              load_pc    = 1'b1;
              state_next = IF_FETCH;
            end
            OP_BEQ, OP_BNE: state_next = IF_RESOLVE;
            default:        state_next = IF_FETCH;
          endcase
        end
      end
      IF_RESOLVE: begin
        if (br_resolved) begin
          state_next = IF_FETCH;
          if (br_taken) begin
            sel     = SEL_BRANCH;
            load_pc = 1'b1;
          end
        end
      end
      default: state_next = IF_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IF_FETCH;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      pc_out      <= RESET_PC;
    end else begin
      state <= state_next;
      if (capture) begin
        instr       <= imem_rdata;
        pc_out      <= pc;
        pc          <= pc + AW'(4);
        imem_req    <= 1'b0;
        instr_valid <= 1'b1;
      end else begin
        if (state == IF_FETCH) imem_req <= 1'b1;
        if (consume)           instr_valid <= 1'b0;
        if (load_pc)           pc <= pc_target;
      end
    end
  end

endmodule
